spi_reg_ctrl: RTL and testbench

// - SPI-slave command controller behind the chip I/O pins. It samples ss/sclk/mosi in the clk domain
//   and decodes framed read/write commands into a small register bank.
// - Register 0 drives the 7-bit display output. miso returns read data.
// - Sits between the top-level io_in/io_out unpacking and the display/output logic.

---
 rtl/spi_reg_ctrl_pkg.sv | 22 ++
 rtl/spi_reg_ctrl_sync_edge.sv | 33 +++
 rtl/spi_reg_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_reg_ctrl_pkg;

    localparam int DATA_W      = 8;
    localparam int CNT_W       = $clog2(DATA_W);

    // Command byte layout: [7] write flag, [6:AW] reserved (must be 0), [AW-1:0] address
    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RSV_MSB = 6;
    localparam int CMD_ADR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RDATA  = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// Synchronises one asynchronous pin into clk and flags its rising/falling edges.
// Latency: sync level valid SYNC_STAGES clk after the pin; rise/fall are combinational on it.
// Backpressure: none; edges are single-cycle strobes.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the raw pin through the flop chain and keep the previous synced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave that decodes framed read/write commands into a small register bank.
// Latency: SYNC_STAGES+1 clk from a pin edge to its effect; writes commit one clk after the 8th rise.
// Backpressure: none; the SPI master must keep f_sclk <= f_clk/4.
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int NREGS       = 4,
    parameter int AW          = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    output logic [6:0] out,
    output logic       frame_err
);

    logic                   ss_s;
    logic                   ss_rise;
    logic                   ss_fall;
    logic                   sclk_lvl_unused;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi_s;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-2:0]      rx_shift;
    logic [DATA_W-2:0]      tx_shift;
    logic [DATA_W-1:0]      rx_byte;
    logic [DATA_W-1:0]      wr_dat;
    logic                   wr_pend;
    logic [AW-1:0]          addr;
    logic [AW-1:0]          addr_inc;
    logic [AW-1:0]          cmd_addr;
    logic                   cmd_rsv;
    logic                   in_frame;
    logic                   byte_done;
    logic [DATA_W-1:0]      regs [NREGS];

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss),
        .sync (ss_s),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .sync (sclk_lvl_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // mosi only needs the same delay as sclk so it lines up with the synced rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s    = mosi_chain[SYNC_STAGES-1];

    // The byte as it stands once the current rise's bit is shifted in
    assign rx_byte   = {rx_shift, mosi_s};
    assign cmd_addr  = rx_byte[CMD_ADR_LSB +: AW];
    assign cmd_rsv   = |rx_byte[CMD_RSV_MSB:AW];
    assign addr_inc  = addr + AW'(1);
    assign in_frame  = (state == ST_CMD) || (state == ST_WDATA) || (state == ST_RDATA);
    assign byte_done = in_frame && sclk_rise && (bit_cnt == CNT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: ss high wins over everything, otherwise decode on command completion
    always_comb begin
        state_nxt = state;
        if (ss_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_nxt = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        if (cmd_rsv) begin
                            state_nxt = ST_IGNORE;
                        end else if (rx_byte[CMD_WR_BIT]) begin
                            state_nxt = ST_WDATA;
                        end else begin
                            state_nxt = ST_RDATA;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Shift registers, bit counter, burst address, register bank and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            wr_dat    <= '0;
            wr_pend   <= 1'b0;
            addr      <= '0;
            miso      <= 1'b0;
            out       <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            wr_pend   <= 1'b0;
            out       <= regs[0][6:0];

            // A completed write byte lands here, ahead of any later reload of the same address
            if (wr_pend) begin
                regs[addr] <= wr_dat;
                addr       <= addr_inc;
            end

            if (ss_s) begin
                // Frame closed: a byte left half-shifted is reported and dropped
                if (ss_rise && in_frame && (bit_cnt != '0)) begin
                    frame_err <= 1'b1;
                end
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso     <= 1'b0;
            end else if (state == ST_IDLE) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso     <= 1'b0;
            end else if (in_frame && sclk_rise) begin
                rx_shift <= rx_byte[DATA_W-2:0];
                bit_cnt  <= bit_cnt + CNT_W'(1);
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            if (cmd_rsv) begin
                                frame_err <= 1'b1;
                            end else begin
                                addr <= cmd_addr;
                                if (!rx_byte[CMD_WR_BIT]) begin
                                    tx_shift <= regs[cmd_addr][DATA_W-2:0];
                                    miso     <= regs[cmd_addr][DATA_W-1];
                                end
                            end
                        end
                        ST_WDATA: begin
                            wr_pend <= 1'b1;
                            wr_dat  <= rx_byte;
                        end
                        ST_RDATA: begin
                            tx_shift <= regs[addr_inc][DATA_W-2:0];
                            miso     <= regs[addr_inc][DATA_W-1];
                            addr     <= addr_inc;
                        end
                        default: begin
                        end
                    endcase
                end
            end else if ((state == ST_RDATA) && sclk_fall && (bit_cnt != '0)) begin
                // The fall right after a byte boundary keeps the freshly loaded MSB on miso
                miso     <= tx_shift[DATA_W-2];
                tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

    localparam int NREGS       = 4;
    localparam int AW          = 2;
    localparam int SYNC_STAGES = 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       ss   = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [6:0] out;
    logic       frame_err;

    int checks  = 0;
    int errors  = 0;
    int half_ns = 60;

    string      err_exp  [$];
    logic [7:0] miso_exp [$];
    logic [7:0] rx_q     [$];

    spi_reg_ctrl #(
        .NREGS       (NREGS),
        .AW          (AW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .out       (out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: frame_err pulses and received miso bytes against the expectation queues
    always @(negedge clk) begin : monitor
        logic [7:0] got;
        logic [7:0] want;
        string      tag;
        if (frame_err !== 1'b0) begin
            checks++;
            if (err_exp.size() == 0) begin
                errors++;
                $display("FAIL frame_err_pulse: got %b expected 0 (no pulse pending)", frame_err);
            end else begin
                tag = err_exp.pop_front();
            end
        end
        while (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            checks++;
            if (miso_exp.size() == 0) begin
                errors++;
                $display("FAIL miso_byte: got %02h expected none", got);
            end else begin
                want = miso_exp.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL miso_byte: got %02h expected %02h", got, want);
                end
            end
        end
    end

    // Mode 0 master: drive mosi, sample miso just before the rise, then rise and fall
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit cap);
        logic [7:0] rx;
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            #(half_ns);
            rx[i] = miso;
            sclk = 1'b1;
            #(half_ns);
            sclk = 1'b0;
        end
        if (cap) rx_q.push_back(rx);
    endtask

    task automatic frame_open();
        repeat (2) @(posedge clk);
        #($urandom_range(1, 9));
        ss = 1'b0;
        #(half_ns);
    endtask

    task automatic frame_close();
        #(half_ns);
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
    endtask

    // Up to five bytes, first byte in bits [39:32]; bytes from index cap_from on are captured
    task automatic frame(input int n, input logic [39:0] bytes, input int cap_from);
        frame_open();
        for (int k = 0; k < n; k++) spi_bits(bytes[39 - 8*k -: 8], 8, k >= cap_from);
        frame_close();
    endtask

    task automatic read_chk(input logic [7:0] cmd, input int n, input logic [31:0] exp);
        for (int k = 0; k < n; k++) miso_exp.push_back(exp[31 - 8*k -: 8]);
        frame(n + 1, {cmd, 32'h0}, 1);
        chk("miso_low_after_ss", {31'd0, miso}, 32'd0);
        chk("miso_bytes_all_seen", miso_exp.size(), 0);
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded 2 ms");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        #23 rst = 1'b0;
        @(negedge clk);
        chk("reset_out", {25'd0, out}, 32'd0);
        chk("reset_miso", {31'd0, miso}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);

        // Single write to reg0
        frame(2, {8'h80, 8'h5B, 24'h0}, 9);
        chk("write_out_5b", {25'd0, out}, 32'h5B);

        // Reset in the middle of a command byte
        frame_open();
        spi_bits(8'h80, 4, 1'b0);
        #7 rst = 1'b1;
        #25;
        chk("midreset_out", {25'd0, out}, 32'd0);
        chk("midreset_miso", {31'd0, miso}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #(half_ns);
        ss = 1'b1;
        repeat (6) @(posedge clk);
        frame(2, {8'h80, 8'h2A, 24'h0}, 9);
        chk("after_reset_write_out", {25'd0, out}, 32'h2A);

        // Burst write regs 1..3, then burst read them back
        frame(4, {8'h81, 8'h11, 8'h22, 8'h33, 8'h0}, 9);
        chk("burst_write_out_keeps_reg0", {25'd0, out}, 32'h2A);
        read_chk(8'h01, 3, 32'h11_22_33_00);

        // Burst write wrapping from reg3 to reg0, then read wrapping the same way
        frame(3, {8'h83, 8'h66, 8'h77, 16'h0}, 9);
        chk("wrap_write_out", {25'd0, out}, 32'h77);
        read_chk(8'h03, 2, 32'h66_77_00_00);

        // Partial command byte
        err_exp.push_back("partial_cmd");
        frame_open();
        spi_bits(8'hA0, 5, 1'b0);
        frame_close();
        chk("partial_cmd_err_seen", err_exp.size(), 0);

        // Partial data byte in a write burst: no write
        err_exp.push_back("partial_data");
        frame_open();
        spi_bits(8'h80, 8, 1'b0);
        spi_bits(8'hFF, 3, 1'b0);
        frame_close();
        chk("partial_data_err_seen", err_exp.size(), 0);
        chk("partial_data_out", {25'd0, out}, 32'h77);

        // Reserved command: one error, following bytes ignored
        err_exp.push_back("reserved_cmd");
        frame(3, {8'h7C, 8'hFF, 8'hFF, 16'h0}, 9);
        chk("reserved_err_seen", err_exp.size(), 0);
        chk("reserved_out", {25'd0, out}, 32'h77);
        read_chk(8'h00, 4, 32'h77_11_22_66);

        // Fastest allowed sclk (f_clk/4) with random phase
        half_ns = 20;
        frame(2, {8'h82, 8'hA5, 24'h0}, 9);
        err_exp.push_back("fast_partial");
        frame_open();
        spi_bits(8'h15, 5, 1'b0);
        frame_close();
        chk("fast_partial_err_seen", err_exp.size(), 0);
        err_exp.push_back("fast_reserved");
        frame(2, {8'h7C, 8'h80, 24'h0}, 9);
        chk("fast_reserved_err_seen", err_exp.size(), 0);
        frame(2, {8'h80, 8'h3C, 24'h0}, 9);
        chk("fast_write_out", {25'd0, out}, 32'h3C);
        half_ns = 60;
        read_chk(8'h00, 4, 32'h3C_11_A5_66);

        repeat (10) @(posedge clk);
        #1;
        chk("no_pending_frame_err", err_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
